wave_sequencer: RTL and testbench

Programmable controller that sequences one saw_tooth_wave generator through a table of segments. Each segment is {amplitude, prescaler, periods}. The block drives the generator's ena/amplitude/prescaler inputs and mirrors the generator's internal counting, so it knows exactly when each period ends. It sits between the host/register interface and the waveform generator, and lets software queue multi-shape waveforms without cycle-accurate intervention.

---
 rtl/wave_pkg.sv | 22 ++
 rtl/wave_seg_timer.sv | 66 ++++++
 rtl/wave_sequencer.sv | 168 ++++++++++++++++
 tb/tb_wave_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types for the wave sequencer.
//   state_e : sequencer FSM states.
//   seg_t   : one segment table entry {amplitude, prescaler, periods}.
//   WAVE_W  : width of every generator-facing quantity.
package wave_pkg;

  localparam int WAVE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [WAVE_W-1:0] amplitude;
    logic [WAVE_W-1:0] prescaler;
    logic [WAVE_W-1:0] periods;
  } seg_t;

endpackage

// File: rtl/wave_seg_timer.sv
// Segment timer: three nested counters that mirror the sawtooth generator.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : zero all counters (generator held in reset)
//   en_i         : count one generator clock
//   amplitude_i  : generator top value
//   prescaler_i  : generator clocks per step minus one
//   periods_i    : sawtooth periods in this segment (non-zero while enabled)
//   seg_end_o    : high on the last cycle of the segment
module wave_seg_timer
  import wave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [WAVE_W-1:0] amplitude_i,
  input  logic [WAVE_W-1:0] prescaler_i,
  input  logic [WAVE_W-1:0] periods_i,
  output logic              seg_end_o
);

  logic [WAVE_W-1:0] psc_q, psc_d;
  logic [WAVE_W-1:0] amp_q, amp_d;
  logic [WAVE_W-1:0] per_q, per_d;
  logic              psc_wrap;
  logic              amp_wrap;

  assign psc_wrap = (psc_q == prescaler_i);
  assign amp_wrap = (amp_q == amplitude_i);

  // Ends exactly when the generator finishes its last step of its last period.
  assign seg_end_o = en_i && psc_wrap && amp_wrap &&
                     (per_q == periods_i - WAVE_W'(1));

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    psc_d = psc_q;
    amp_d = amp_q;
    per_d = per_q;
    if (clr_i) begin
      psc_d = '0;
      amp_d = '0;
      per_d = '0;
    end else if (en_i) begin
      psc_d = psc_wrap ? '0 : psc_q + WAVE_W'(1);
      if (psc_wrap) begin
        amp_d = amp_wrap ? '0 : amp_q + WAVE_W'(1);
        if (amp_wrap) per_d = per_q + WAVE_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
      amp_q <= '0;
      per_q <= '0;
    end else begin
      psc_q <= psc_d;
      amp_q <= amp_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Wave sequencer: plays a table of {amplitude, prescaler, periods} segments
// through one sawtooth generator, tracking period ends via wave_seg_timer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_*            : table write port (ignored while busy)
//   num_segs, loop  : play entries 0..num_segs-1, optionally repeating
//   start, stop     : begin playback (IDLE only) / abort playback
//   gen_*           : generator ena/amplitude/prescaler
//   busy, done      : playback active / one-cycle completion pulse
//   seg_idx         : current or last segment index
module wave_sequencer
  import wave_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WAVE_W-1:0] wr_amplitude,
  input  logic [WAVE_W-1:0] wr_prescaler,
  input  logic [WAVE_W-1:0] wr_periods,
  input  logic [AW:0]       num_segs,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic              gen_ena,
  output logic [WAVE_W-1:0] gen_amplitude,
  output logic [WAVE_W-1:0] gen_prescaler,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     seg_idx
);

  seg_t              table_q [DEPTH];
  seg_t              cur_seg;

  state_e            state_q, state_d;
  logic [AW-1:0]     seg_idx_q, seg_idx_d;
  logic [AW:0]       num_q, num_d;
  logic              loop_q, loop_d;
  logic [WAVE_W-1:0] amp_q, amp_d;
  logic [WAVE_W-1:0] psc_q, psc_d;
  logic [WAVE_W-1:0] per_q, per_d;
  logic              ena_q, busy_q, done_q;
  logic              load_seg;
  logic              seg_end;
  logic              is_last;
  state_e            adv_state;
  logic [AW-1:0]     adv_idx;

  // NOTE: the segment table is RAM and deliberately has no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) table_q[wr_addr] <= '{wr_amplitude, wr_prescaler, wr_periods};
  end

  assign cur_seg = table_q[seg_idx_q];

  wave_seg_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (state_q == ST_LOAD),
    .en_i        (state_q == ST_RUN),
    .amplitude_i (amp_q),
    .prescaler_i (psc_q),
    .periods_i   (per_q),
    .seg_end_o   (seg_end)
  );

  // Where to go once the current segment is finished or skipped.
  assign is_last = ({1'b0, seg_idx_q} == num_q - (AW+1)'(1));

  always_comb begin
    adv_state = ST_LOAD;
    adv_idx   = seg_idx_q + AW'(1);
    if (is_last) begin
      if (loop_q) begin
        adv_idx = '0;
      end else begin
        adv_state = ST_DONE;
        adv_idx   = seg_idx_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    num_d     = num_q;
    loop_d    = loop_q;
    load_seg  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = num_segs;
          loop_d    = loop;
          seg_idx_d = '0;
          state_d   = (num_segs == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          load_seg = 1'b1;
          if (cur_seg.periods == '0) begin
            state_d   = adv_state;
            seg_idx_d = adv_idx;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // stop outranks a coincident segment end
        if (stop) begin
          state_d = ST_IDLE;
        end else if (seg_end) begin
          state_d   = adv_state;
          seg_idx_d = adv_idx;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Generator settings are captured at the end of LOAD so they are stable
  // for the whole RUN; an aborted LOAD leaves the old values in place.
  assign amp_d = load_seg ? cur_seg.amplitude : amp_q;
  assign psc_d = load_seg ? cur_seg.prescaler : psc_q;
  assign per_d = load_seg ? cur_seg.periods   : per_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      seg_idx_q <= '0;
      num_q     <= '0;
      loop_q    <= 1'b0;
      amp_q     <= '0;
      psc_q     <= '0;
      per_q     <= '0;
      ena_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      num_q     <= num_d;
      loop_q    <= loop_d;
      amp_q     <= amp_d;
      psc_q     <= psc_d;
      per_q     <= per_d;
      // status flags are decoded from the next state so they are registered
      ena_q     <= (state_d == ST_RUN);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign gen_ena       = ena_q;
  assign gen_amplitude = amp_q;
  assign gen_prescaler = psc_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign seg_idx       = seg_idx_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: a segment-level model predicts the
// output trace of each playback; a compare process checks it every cycle and
// directed scenarios pin key cycle numbers with literal values.
module tb_wave_sequencer;
  import wave_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_amplitude, wr_prescaler, wr_periods;
  logic [3:0]  num_segs;
  logic        loop, start, stop;
  logic        gen_ena, busy, done;
  logic [15:0] gen_amplitude, gen_prescaler;
  logic [2:0]  seg_idx;

  wave_sequencer #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_amplitude(wr_amplitude), .wr_prescaler(wr_prescaler), .wr_periods(wr_periods),
    .num_segs(num_segs), .loop(loop), .start(start), .stop(stop),
    .gen_ena(gen_ena), .gen_amplitude(gen_amplitude), .gen_prescaler(gen_prescaler),
    .busy(busy), .done(done), .seg_idx(seg_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit ena, busy, done;
    int seg, amp, psc;
  } rec_t;

  seg_t tbl_m [8];
  rec_t q [$];
  rec_t idle_rec;
  bit   cmp_en = 1'b0;

  // Expected outputs for the start cycle and every following cycle of playback.
  function automatic void model_start(input int num, input bit lp);
    rec_t r;
    int   k;
    int   len;
    r = idle_rec;
    r.ena = 0; r.busy = 0; r.done = 0;
    q.push_back(r);
    if (num == 0) begin
      r.busy = 1; r.done = 1; r.seg = 0;
      q.push_back(r);
      return;
    end
    k = 0;
    while (1) begin
      r.ena = 0; r.busy = 1; r.done = 0; r.seg = k;
      q.push_back(r);
      r.amp = int'(tbl_m[k].amplitude);
      r.psc = int'(tbl_m[k].prescaler);
      len = int'(tbl_m[k].periods) * (r.amp + 1) * (r.psc + 1);
      for (int j = 0; j < len; j++) begin
        r.ena = 1;
        q.push_back(r);
      end
      if (q.size() > 150) return;
      if (k == num - 1) begin
        if (lp) k = 0;
        else begin
          r.ena = 0; r.done = 1;
          q.push_back(r);
          return;
        end
      end else k++;
    end
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (rst_n && cmp_en) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        idle_rec = r;
        idle_rec.ena = 0; idle_rec.busy = 0; idle_rec.done = 0;
      end else begin
        r = idle_rec;
      end
      check("cyc_gen_ena",       32'(gen_ena),       32'(r.ena));
      check("cyc_busy",          32'(busy),          32'(r.busy));
      check("cyc_done",          32'(done),          32'(r.done));
      check("cyc_seg_idx",       32'(seg_idx),       32'(r.seg));
      check("cyc_gen_amplitude", 32'(gen_amplitude), 32'(r.amp));
      check("cyc_gen_prescaler", 32'(gen_prescaler), 32'(r.psc));
    end
  end

  // ---------------- stimulus helpers ----------------
  bit        s_ena  [64];
  bit        s_busy [64];
  bit        s_done [64];
  int        s_seg  [64];
  int        s_amp  [64];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int amp, input int psc, input int per);
    step();
    wr_en = 1'b1; wr_addr = 3'(a);
    wr_amplitude = 16'(amp); wr_prescaler = 16'(psc); wr_periods = 16'(per);
    tbl_m[a] = '{16'(amp), 16'(psc), 16'(per)};
    step();
    wr_en = 1'b0;
  endtask

  // Index i of the sample arrays is the cycle i after the start cycle (i=0).
  // A table write at wr_at targets entry 0 while busy and must be ignored.
  task automatic run(input int n, input int nsegs, input bit lp, input int stop_at, input int wr_at);
    for (int i = 0; i < n; i++) begin
      step();
      start = (i == 0);
      stop  = (i == stop_at);
      wr_en = (i == wr_at);
      if (i == 0) begin
        num_segs = 4'(nsegs);
        loop     = lp;
        model_start(nsegs, lp);
      end
      if (i == wr_at) begin
        wr_addr = 3'd0; wr_amplitude = 16'd9; wr_prescaler = 16'd0; wr_periods = 16'd1;
      end
      if (i == stop_at) begin
        while (q.size() > 1) void'(q.pop_back());
      end
      s_ena[i] = gen_ena; s_busy[i] = busy; s_done[i] = done;
      s_seg[i] = int'(seg_idx); s_amp[i] = int'(gen_amplitude);
    end
    step();
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic summarize(input int n, output int first_ena, output int ena_cnt,
                           output int done_cyc, output int done_cnt);
    first_ena = -1; ena_cnt = 0; done_cyc = -1; done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (s_ena[i]) begin
        ena_cnt++;
        if (first_ena < 0) first_ena = i;
      end
      if (s_done[i]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = i;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required below 100000 ns");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int fe, ec, dc, dn;
    int pat [7];
    pat = '{0, 1, 1, 0, 1, 1, 0};
    idle_rec = '{0, 0, 0, 0, 0, 0};
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_amplitude = 0; wr_prescaler = 0; wr_periods = 0;
    num_segs = 0; loop = 0; start = 0; stop = 0;
    #12;
    check("reset_gen_ena", 32'(gen_ena), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_seg_idx", 32'(seg_idx), 0);
    check("reset_gen_amplitude", 32'(gen_amplitude), 0);
    check("reset_gen_prescaler", 32'(gen_prescaler), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Single segment {3,1,2}: 2*4*2 = 16 RUN cycles.
    write_entry(0, 3, 1, 2);
    run(22, 1, 0, -1, -1);
    summarize(22, fe, ec, dc, dn);
    check("t1_first_ena", fe, 2);
    check("t1_ena_cycles", ec, 16);
    check("t1_done_cycle", dc, 18);
    check("t1_done_count", dn, 1);
    check("t1_busy_c18", 32'(s_busy[18]), 1);
    check("t1_busy_c19", 32'(s_busy[19]), 0);
    check("t1_amp_c2", s_amp[2], 3);

    // Three segments, middle one skipped.
    write_entry(0, 2, 0, 1);
    write_entry(1, 5, 0, 0);
    write_entry(2, 1, 2, 3);
    run(30, 3, 0, -1, -1);
    summarize(30, fe, ec, dc, dn);
    check("t2_ena_cycles", ec, 21);
    check("t2_ena_c4", 32'(s_ena[4]), 1);
    check("t2_ena_c5", 32'(s_ena[5]), 0);
    check("t2_ena_c6", 32'(s_ena[6]), 0);
    check("t2_seg_c5", s_seg[5], 1);
    check("t2_seg_c6", s_seg[6], 2);
    check("t2_amp_c7", s_amp[7], 1);
    check("t2_done_cycle", dc, 25);

    // Looping single segment {1,0,1}, stopped mid-RUN.
    write_entry(0, 1, 0, 1);
    run(12, 1, 1, 8, -1);
    summarize(12, fe, ec, dc, dn);
    for (int i = 0; i < 7; i++) check($sformatf("t3_pattern_c%0d", i + 1), 32'(s_ena[i + 1]), 32'(pat[i]));
    check("t3_ena_c8", 32'(s_ena[8]), 1);
    check("t3_ena_after_stop", 32'(s_ena[9]), 0);
    check("t3_busy_after_stop", 32'(s_busy[9]), 0);
    check("t3_no_done", dn, 0);

    // num_segs = 0: straight to DONE.
    run(5, 0, 0, -1, -1);
    summarize(5, fe, ec, dc, dn);
    check("t4_done_cycle", dc, 1);
    check("t4_no_ena", ec, 0);
    check("t4_busy_c2", 32'(s_busy[2]), 0);

    // Write while busy is ignored: second loop pass still uses amplitude 3.
    write_entry(0, 3, 1, 2);
    run(34, 1, 1, 30, 5);
    summarize(34, fe, ec, dc, dn);
    check("t5_amp_second_pass", s_amp[20], 3);
    check("t5_ena_cycles", ec, 28);
    check("t5_no_done", dn, 0);
    write_entry(0, 9, 0, 1);
    run(14, 1, 0, -1, -1);
    summarize(14, fe, ec, dc, dn);
    check("t5_new_amp", s_amp[2], 9);
    check("t5_new_ena_cycles", ec, 10);
    check("t5_new_done_cycle", dc, 12);

    // Asynchronous reset in the middle of RUN.
    write_entry(0, 3, 1, 2);
    run(6, 1, 0, -1, -1);
    check("t6_running", 32'(gen_ena), 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    idle_rec = '{0, 0, 0, 0, 0, 0};
    #1;
    check("t6_async_ena", 32'(gen_ena), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_amp", 32'(gen_amplitude), 0);
    step();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_idle_busy", 32'(busy), 0);
      check("t6_idle_ena", 32'(gen_ena), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
